// File: rtl/stdcell_and2_bist.sv
// Built-in self-test sequencer for a 2-input AND standard cell: drives LFSR
// vectors onto A/B, checks Y against A&B after CHK_LAT cycles, reports results.
module stdcell_and2_bist #(
  parameter int unsigned CNT_W   = 16,
  parameter logic [7:0]  SEED    = 8'hA5,
  parameter int unsigned CHK_LAT = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] N_VEC,
  output logic             A,
  output logic             B,
  input  logic             Y,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] FIRST_ERR_IDX
);

  localparam logic [7:0]  SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam int unsigned PIPE_D     = (CHK_LAT > 0) ? CHK_LAT : 1;
  localparam logic [2:0]  DRAIN_LAST = 3'(PIPE_D - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_next;
  logic [CNT_W-1:0] vec_cnt;
  logic [CNT_W-1:0] vec_idx;
  logic [2:0]       drain_cnt;
  logic             chk_vld;
  logic             chk_exp;
  logic [CNT_W-1:0] chk_idx;
  logic             mismatch;
  logic [CNT_W-1:0] err_next;
  logic [CNT_W-1:0] first_next;

  assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

  // A/B are registered, so during RUN they already hold the vector under test.
  if (CHK_LAT == 0) begin : g_direct
    assign chk_vld = (state == ST_RUN);
    assign chk_exp = A & B;
    assign chk_idx = vec_idx;
  end else begin : g_pipe
    logic             vld_q [PIPE_D];
    logic             exp_q [PIPE_D];
    logic [CNT_W-1:0] idx_q [PIPE_D];

    always_ff @(posedge CLK) begin
      if (RST) begin
        for (int unsigned i = 0; i < PIPE_D; i++) vld_q[i] <= 1'b0;
      end else begin
        vld_q[0] <= (state == ST_RUN);
        exp_q[0] <= A & B;
        idx_q[0] <= vec_idx;
        for (int unsigned i = 1; i < PIPE_D; i++) begin
          vld_q[i] <= vld_q[i-1];
          exp_q[i] <= exp_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign chk_vld = vld_q[PIPE_D-1];
    assign chk_exp = exp_q[PIPE_D-1];
    assign chk_idx = idx_q[PIPE_D-1];
  end

  // Y only matters when a valid check reaches the end of the pipeline.
  always_comb begin
    mismatch   = chk_vld && (Y != chk_exp);
    err_next   = ERR_CNT;
    first_next = FIRST_ERR_IDX;
    if (mismatch) begin
      if (ERR_CNT != '1) err_next = ERR_CNT + 1'b1;
      if (FIRST_ERR_IDX == '1) first_next = chk_idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      lfsr          <= SEED_EFF;
      vec_cnt       <= '0;
      vec_idx       <= '0;
      drain_cnt     <= '0;
      A             <= 1'b0;
      B             <= 1'b0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      PASS          <= 1'b0;
      ERR_CNT       <= '0;
      FIRST_ERR_IDX <= '1;
    end else begin
      ERR_CNT       <= err_next;
      FIRST_ERR_IDX <= first_next;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            lfsr          <= SEED_EFF;
            vec_idx       <= '0;
            vec_cnt       <= N_VEC;
            ERR_CNT       <= '0;
            FIRST_ERR_IDX <= '1;
            if (N_VEC != '0) begin
              state <= ST_RUN;
              BUSY  <= 1'b1;
              DONE  <= 1'b0;
              PASS  <= 1'b0;
              A     <= SEED_EFF[0];
              B     <= SEED_EFF[1];
            end else begin
              state <= ST_DONE;
              DONE  <= 1'b1;
              PASS  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          vec_idx <= vec_idx + 1'b1;
          vec_cnt <= vec_cnt - 1'b1;
          if (vec_cnt == CNT_W'(1)) begin
            A <= 1'b0;
            B <= 1'b0;
            if (CHK_LAT == 0) begin
              state <= ST_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              PASS  <= (err_next == '0);
            end else begin
              state     <= ST_DRAIN;
              drain_cnt <= DRAIN_LAST;
            end
          end else begin
            lfsr <= lfsr_next;
            A    <= lfsr_next[0];
            B    <= lfsr_next[1];
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
